// File: rtl/inst_fetch.sv
// Instruction fetch: owns the fetch PC, issues single-outstanding word reads, buffers replies in a small FIFO.
// Latency: ack-to-visible 1 cycle; redirect flushes the FIFO and drains any in-flight read before refetching.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DRAIN
    } state_t;

    state_t         state_q, state_d;
    logic [31:0]    fetch_pc_q, fetch_pc_d;
    logic [31:0]    addr_q, addr_d;
    logic [PW-1:0]  rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]  count_q;
    logic [31:0]    dat_q [DEPTH];
    logic [31:0]    pc_q  [DEPTH];

    logic           pop, push, flush;
    logic [CW-1:0]  cnt_after_pop, cnt_after_push;
    logic [31:0]    redir_tgt;

    assign inst_valid_o   = (count_q != '0);
    assign pop            = inst_ready_i & inst_valid_o;
    assign cnt_after_pop  = count_q - CW'(pop);
    assign cnt_after_push = cnt_after_pop + CW'(1);
    assign redir_tgt      = {redirect_pc_i[31:2], 2'b00};

    assign imem_req_o  = (state_q != S_IDLE);
    assign imem_addr_o = addr_q;
    assign inst_o      = inst_valid_o ? dat_q[rd_ptr_q] : NOP;
    assign inst_pc_o   = inst_valid_o ? pc_q[rd_ptr_q]  : 32'h0;

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        addr_d     = addr_q;
        push       = 1'b0;
        flush      = 1'b0;
        if (redirect_i) begin
            flush      = 1'b1;
            fetch_pc_d = redir_tgt;
            // An unacked read cannot be cancelled, so wait it out before using the new target.
            if (state_q == S_IDLE || imem_ack_i) begin
                state_d = S_FETCH;
                addr_d  = redir_tgt;
            end else begin
                state_d = S_DRAIN;
            end
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (cnt_after_pop < DEPTH_C) begin
                        state_d = S_FETCH;
                        addr_d  = fetch_pc_q;
                    end
                end
                S_FETCH: begin
                    if (imem_ack_i) begin
                        push       = 1'b1;
                        fetch_pc_d = fetch_pc_q + 32'd4;
                        if (cnt_after_push < DEPTH_C) begin
                            addr_d = fetch_pc_q + 32'd4;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (imem_ack_i) begin
                        state_d = S_FETCH;
                        addr_d  = fetch_pc_q;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            fetch_pc_q <= RESET_PC;
            addr_q     <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            addr_q     <= addr_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            count_q <= count_q + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset; occupancy is tracked by count_q.
    always_ff @(posedge clk_i) begin
        if (push) begin
            dat_q[wr_ptr_q] <= imem_rdata_i;
            pc_q[wr_ptr_q]  <= addr_q;
        end
    end

endmodule
